spi_sram_ctrl: RTL and testbench
================================

# spi_sram_ctrl

SPI-slave command sequencer for the 256x8 SRAM. It deserializes a command byte and an address byte from MOSI, then either captures a write byte and strobes the SRAM write enable, or fetches the addressed byte and serializes it onto MISO. It sits between the SPI pins and the SRAM macro and owns all bit counting, byte framing and SRAM port control.

## Interface
- IDLE_MISO, 1'b0, value driven on miso whenever no read data is being shifted
- SCK  in  1  SPI serial clock; the only clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- cs_n  in  1  chip select, active low, sampled on rising SCK
- mosi  in  1  serial data in, LSB first
- miso  out  1  serial data out, LSB first
- sram_addr  out  8  SRAM address
- sram_din  out  8  SRAM write data
- sram_we  out  1  SRAM write strobe, one-cycle pulse
- sram_dout  in  8  SRAM read data, combinational from sram_addr
- busy  out  1  high whenever state != IDLE
- err  out  1  illegal command seen; held until cs_n high or reset

## Operation
- States: IDLE, CMD, ADDR, WDATA, RDATA, HOLD, ERR.
- Shift rule, CMD/ADDR/WDATA: shreg <= {mosi, shreg[7:1]}; 3-bit bit counter; byte completes on the edge with count==7, and the completed byte is {mosi, shreg[7:1]}.
- IDLE: first rising edge with cs_n low captures command bit 0 and enters CMD.
- CMD byte complete:
  - 8'h02 -> ADDR, write.
  - 8'h03 -> ADDR, read.
  - Any other value -> ERR with err<=1. In ERR, mosi is ignored and miso = IDLE_MISO.
- ADDR byte complete: sram_addr <= byte; next state is WDATA or RDATA.
- WDATA byte complete: sram_din <= byte, sram_we <= 1. sram_we returns to 0 on the following edge.
- RDATA: the first edge loads the tx register from sram_dout and sets miso <= sram_dout[0]. Each following edge drives the next bit; bit 7 is driven on the 8th edge.
- Without burst (see Configuration), after one data byte: -> HOLD. In HOLD, no further writes occur, mosi is ignored and miso = IDLE_MISO.
- cs_n high sampled in any state:
  - Go to IDLE on that edge and clear the bit counter.
  - A partial byte is discarded; no write is issued for it.
  - sram_we <= 0, miso <= IDLE_MISO, err <= 0.
  - sram_addr and sram_din hold their values.
- rst_n low has priority over cs_n and all other inputs.

## Timing
- Reset values: miso=IDLE_MISO, sram_addr=0, sram_din=0, sram_we=0, busy=0, err=0, state IDLE, counter 0.
- Edge numbering counts rising edges from the first one with cs_n low, starting at 1.
- Edges 1-8: command. Edges 9-16: address; sram_addr is valid after edge 16.
- Write: sram_we is high for exactly the cycle after edge 24 (data byte 0).
- Read: miso carries data bit i after edge 17+i. The master samples it on edge 18+i.
- err asserts after edge 8.
- busy rises after edge 1 and falls after the edge where cs_n is sampled high.
- sram_dout must settle within one SCK period of a sram_addr change.

## Configuration
- SPI_SRAM_BURST_EN defined: sequential mode. After each data byte the controller stays in WDATA or RDATA. sram_addr increments by 1, wrapping 8'hFF -> 8'h00.
  - Write: the increment occurs on the edge after the write pulse, i.e. bit 0 of the next byte.
  - Read: the increment occurs on the edge driving bit 7. The next edge loads the new sram_dout.
- Undefined: exactly one data byte per cs_n frame; HOLD afterward; sram_addr never increments.

## Structure
- Package spi_sram_pkg holds:
  - the state enum;
  - CMD_WRITE=8'h02 and CMD_READ=8'h03;
  - BYTE_W=8 and BIT_CNT_W=3.
- Sub-module spi_byte_shifter: 8-bit shift register, 3-bit bit counter, byte_done flag, parallel-load port for tx.
  - Instantiated once; serves both rx and tx.

## Test plan
- Reset: assert rst_n low mid-frame -> all outputs at reset values on the next edge; no sram_we pulse.
- Write: frame 02, 5A, C3 -> sram_addr=8'h5A after edge 16; sram_din=8'hC3 with sram_we high for exactly one cycle after edge 24.
- Read: preload addr 5A=C3, frame 03, 5A -> miso sequence 1,1,0,0,0,0,1,1 after edges 17-24.
- Illegal command: send 8'h07 -> err=1 after edge 8, no sram_we for the rest of the frame; err=0 after cs_n rises.
- Abort: raise cs_n after 5 data bits of a write -> no sram_we, busy=0; the next frame decodes normally.
- Burst (SPI_SRAM_BURST_EN): write 02, FF, 11, 22 -> writes FF=11 and 00=22. Without the macro -> only FF=11; sram_addr stays FF.

Source files
------------

// File: rtl/spi_sram_pkg.sv
// ----------------------------------------------------------------------------
// spi_sram_pkg
// Shared types and constants for the SPI-slave SRAM command sequencer.
//   state_t    : controller state encoding
//   CMD_WRITE  : command byte selecting a write transaction
//   CMD_READ   : command byte selecting a read transaction
//   BYTE_W     : serial byte width
//   BIT_CNT_W  : width of the bit-within-byte counter
// ----------------------------------------------------------------------------
package spi_sram_pkg;

    localparam int BYTE_W    = 8;
    localparam int BIT_CNT_W = 3;

    localparam logic [BYTE_W-1:0] CMD_WRITE = 8'h02;
    localparam logic [BYTE_W-1:0] CMD_READ  = 8'h03;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_WDATA = 3'd3,
        ST_RDATA = 3'd4,
        ST_HOLD  = 3'd5,
        ST_ERR   = 3'd6
    } state_t;

endpackage

// File: rtl/spi_byte_shifter.sv
// ----------------------------------------------------------------------------
// spi_byte_shifter
// Shared rx/tx byte shifter: one 8-bit register shifting LSB first with a
// 3-bit bit counter. Received bits enter at the top; transmit bits leave at
// the bottom, so the same register serves both directions.
// Ports:
//   clk       : serial clock (rising edge)
//   rst_n     : synchronous active-low reset
//   clr       : clear bit counter (frame end)
//   shift_en  : shift sdi in at the top, advance counter
//   load_en   : parallel load for transmit, advance counter
//   sdi       : serial data in
//   load_hi   : tx byte bits [7:1]; bit 0 goes straight to the pin on load
//   tx_bit    : next bit to transmit
//   byte_done : this edge completes a byte (counter at 7 and advancing)
//   byte_out  : completed byte including the bit sampled on this edge
//   bit_cnt   : current bit counter
// ----------------------------------------------------------------------------
module spi_byte_shifter
    import spi_sram_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 shift_en,
    input  logic                 load_en,
    input  logic                 sdi,
    input  logic [BYTE_W-2:0]    load_hi,
    output logic                 tx_bit,
    output logic                 byte_done,
    output logic [BYTE_W-1:0]    byte_out,
    output logic [BIT_CNT_W-1:0] bit_cnt
);

    logic [BYTE_W-1:0] shreg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (clr) begin
            bit_cnt <= '0;
        end else if (load_en) begin
            // Bit 0 is driven out on the load edge, so the register holds
            // the remaining bits already aligned for the next shift.
            shreg   <= {sdi, load_hi};
            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
        end else if (shift_en) begin
            shreg   <= {sdi, shreg[BYTE_W-1:1]};
            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
        end
    end

    assign byte_out  = {sdi, shreg[BYTE_W-1:1]};
    assign byte_done = (shift_en | load_en) & ~clr & (bit_cnt == '1);
    assign tx_bit    = shreg[0];

endmodule

// File: rtl/spi_sram_ctrl.sv
// ----------------------------------------------------------------------------
// spi_sram_ctrl
// SPI-slave command sequencer for a 256x8 SRAM. Receives a command byte and
// an address byte (LSB first), then either writes one data byte into the
// SRAM or reads the addressed byte back out on miso.
// Build option: define SPI_SRAM_BURST_EN for sequential mode (address
// auto-increments after each data byte, frame continues until cs_n rises).
// Ports:
//   SCK       : serial clock, all state updates on rising edge
//   rst_n     : synchronous active-low reset
//   cs_n      : chip select, active low
//   mosi      : serial data in
//   miso      : serial data out (IDLE_MISO when not shifting read data)
//   sram_addr : SRAM address
//   sram_din  : SRAM write data
//   sram_we   : SRAM write strobe, one-cycle pulse
//   sram_dout : SRAM read data, combinational from sram_addr
//   busy      : controller not idle
//   err       : illegal command seen in this frame
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no frame; first edge with cs_n low takes command bit 0
// ST_CMD   | receiving command byte
// ST_ADDR  | receiving address byte
// ST_WDATA | receiving write data byte(s)
// ST_RDATA | transmitting read data byte(s)
// ST_HOLD  | single transfer done, waiting for cs_n high
// ST_ERR   | illegal command, waiting for cs_n high
// ----------------------------------------------------------------------------
module spi_sram_ctrl
    import spi_sram_pkg::*;
#(
    parameter logic IDLE_MISO = 1'b0
) (
    input  logic              SCK,
    input  logic              rst_n,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic [BYTE_W-1:0] sram_addr,
    output logic [BYTE_W-1:0] sram_din,
    output logic              sram_we,
    input  logic [BYTE_W-1:0] sram_dout,
    output logic              busy,
    output logic              err
);

    state_t                 state;
    logic                   is_read;
    logic                   shift_en;
    logic                   load_en;
    logic                   tx_bit;
    logic                   byte_done;
    logic [BYTE_W-1:0]      byte_val;
    logic [BIT_CNT_W-1:0]   bit_cnt;

    // In RDATA a counter value of 0 marks the first edge of a byte, which
    // fetches sram_dout instead of shifting.
    always_comb begin
        shift_en = 1'b0;
        load_en  = 1'b0;
        if (!cs_n) begin
            case (state)
                ST_IDLE, ST_CMD, ST_ADDR, ST_WDATA: shift_en = 1'b1;
                ST_RDATA: begin
                    if (bit_cnt == '0) begin
                        load_en = 1'b1;
                    end else begin
                        shift_en = 1'b1;
                    end
                end
                default: begin
                    shift_en = 1'b0;
                    load_en  = 1'b0;
                end
            endcase
        end
    end

    spi_byte_shifter u_shifter (
        .clk       (SCK),
        .rst_n     (rst_n),
        .clr       (cs_n),
        .shift_en  (shift_en),
        .load_en   (load_en),
        .sdi       (mosi),
        .load_hi   (sram_dout[BYTE_W-1:1]),
        .tx_bit    (tx_bit),
        .byte_done (byte_done),
        .byte_out  (byte_val),
        .bit_cnt   (bit_cnt)
    );

    always_ff @(posedge SCK) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            is_read   <= 1'b0;
            sram_addr <= '0;
            sram_din  <= '0;
            sram_we   <= 1'b0;
            miso      <= IDLE_MISO;
            err       <= 1'b0;
        end else if (cs_n) begin
            // Frame end: any partial byte is dropped; address and data
            // registers keep their last values.
            state   <= ST_IDLE;
            sram_we <= 1'b0;
            miso    <= IDLE_MISO;
            err     <= 1'b0;
        end else begin
            sram_we <= 1'b0;
            case (state)
                ST_IDLE: begin
                    state <= ST_CMD;
                end
                ST_CMD: begin
                    if (byte_done) begin
                        if (byte_val == CMD_WRITE) begin
                            state   <= ST_ADDR;
                            is_read <= 1'b0;
                        end else if (byte_val == CMD_READ) begin
                            state   <= ST_ADDR;
                            is_read <= 1'b1;
                        end else begin
                            state <= ST_ERR;
                            err   <= 1'b1;
                        end
                    end
                end
                ST_ADDR: begin
                    if (byte_done) begin
                        sram_addr <= byte_val;
                        state     <= is_read ? ST_RDATA : ST_WDATA;
                    end
                end
                ST_WDATA: begin
`ifdef SPI_SRAM_BURST_EN
                    // Advance on the edge after the strobe so the write
                    // lands at the address it was issued with.
                    if (sram_we) begin
                        sram_addr <= sram_addr + 8'd1;
                    end
`endif
                    if (byte_done) begin
                        sram_din <= byte_val;
                        sram_we  <= 1'b1;
`ifndef SPI_SRAM_BURST_EN
                        state    <= ST_HOLD;
`endif
                    end
                end
                ST_RDATA: begin
                    miso <= load_en ? sram_dout[0] : tx_bit;
                    if (byte_done) begin
`ifdef SPI_SRAM_BURST_EN
                        // Next edge reloads from the new address.
                        sram_addr <= sram_addr + 8'd1;
`else
                        state     <= ST_HOLD;
`endif
                    end
                end
                ST_HOLD, ST_ERR: begin
                    miso <= IDLE_MISO;
                end
                default: begin
                    state <= ST_IDLE;
                    miso  <= IDLE_MISO;
                end
            endcase
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_spi_sram_ctrl.sv
module tb_spi_sram_ctrl;

    logic       SCK = 1'b0;
    logic       rst_n;
    logic       cs_n;
    logic       mosi;
    logic       miso;
    logic [7:0] sram_addr;
    logic [7:0] sram_din;
    logic       sram_we;
    logic [7:0] sram_dout;
    logic       busy;
    logic       err;

    logic [7:0] mem [256];
    logic       mem_clr;
    int         we_cnt;

    int n_chk = 0;
    int n_bad = 0;

    spi_sram_ctrl dut (
        .SCK       (SCK),
        .rst_n     (rst_n),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .miso      (miso),
        .sram_addr (sram_addr),
        .sram_din  (sram_din),
        .sram_we   (sram_we),
        .sram_dout (sram_dout),
        .busy      (busy),
        .err       (err)
    );

    always #5 SCK = ~SCK;

    assign sram_dout = mem[sram_addr];

    always @(posedge SCK) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            we_cnt <= 0;
        end else if (sram_we) begin
            mem[sram_addr] <= sram_din;
            we_cnt <= we_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One rising edge with the given pins; returns 1 time unit after it.
    task automatic bit_edge(input logic cs, input logic m);
        @(negedge SCK);
        cs_n = cs;
        mosi = m;
        @(posedge SCK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) bit_edge(1'b0, b[i]);
    endtask

    task automatic end_frame();
        bit_edge(1'b1, 1'b0);
    endtask

    logic [7:0] rd_exp;
    int         we_base;

    initial begin
        rst_n   = 1'b0;
        cs_n    = 1'b1;
        mosi    = 1'b0;
        mem_clr = 1'b1;
        repeat (3) @(posedge SCK);
        #1;
        check("rst_miso", miso, 0);
        check("rst_addr", sram_addr, 0);
        check("rst_din",  sram_din, 0);
        check("rst_we",   sram_we, 0);
        check("rst_busy", busy, 0);
        check("rst_err",  err, 0);
        @(negedge SCK);
        rst_n   = 1'b1;
        mem_clr = 1'b0;
        end_frame();

        // Write 02, 5A, C3
        bit_edge(1'b0, 1'b0);
        check("wr_busy_e1", busy, 1);
        for (int i = 1; i < 8; i++) bit_edge(1'b0, CMD_BITS(i));
        send_byte(8'h5A);
        check("wr_addr_e16", sram_addr, 8'h5A);
        rd_exp = 8'hC3;
        for (int i = 0; i < 7; i++) bit_edge(1'b0, rd_exp[i]);
        check("wr_we_e23", sram_we, 0);
        bit_edge(1'b0, rd_exp[7]);
        check("wr_we_e24", sram_we, 1);
        check("wr_din_e24", sram_din, 8'hC3);
        bit_edge(1'b0, 1'b1);
        check("wr_we_e25", sram_we, 0);
        check("wr_hold_busy", busy, 1);
        bit_edge(1'b0, 1'b1);
        end_frame();
        check("wr_busy_end", busy, 0);
        check("wr_mem", mem[8'h5A], 8'hC3);
        check("wr_we_cnt", we_cnt, 1);

        // Read back 5A: expect C3 LSB first = 1,1,0,0,0,0,1,1
        send_byte(8'h03);
        send_byte(8'h5A);
        check("rd_miso_e16", miso, 0);
        for (int i = 0; i < 8; i++) begin
            bit_edge(1'b0, 1'b0);
            check($sformatf("rd_bit%0d", i), miso, rd_exp[i]);
        end
        bit_edge(1'b0, 1'b0);
        check("rd_hold_miso", miso, 0);
        end_frame();
        check("rd_we_cnt", we_cnt, 1);
        check("rd_busy_end", busy, 0);

        // Illegal command 07
        for (int i = 0; i < 7; i++) bit_edge(1'b0, ILL_BITS(i));
        check("ill_err_e7", err, 0);
        bit_edge(1'b0, 1'b0);
        check("ill_err_e8", err, 1);
        send_byte(8'h5A);
        send_byte(8'hFF);
        check("ill_err_hold", err, 1);
        check("ill_miso", miso, 0);
        check("ill_we_cnt", we_cnt, 1);
        end_frame();
        check("ill_err_end", err, 0);
        check("ill_busy_end", busy, 0);

        // Abort after 5 data bits
        send_byte(8'h02);
        send_byte(8'h10);
        for (int i = 0; i < 5; i++) bit_edge(1'b0, 1'b1);
        end_frame();
        check("abort_busy", busy, 0);
        check("abort_we_cnt", we_cnt, 1);
        check("abort_mem", mem[8'h10], 8'h00);
        send_byte(8'h02);
        send_byte(8'h10);
        send_byte(8'h77);
        bit_edge(1'b0, 1'b0);
        end_frame();
        check("after_abort_mem", mem[8'h10], 8'h77);
        check("after_abort_we_cnt", we_cnt, 2);

        // Burst-style frame 02, FF, 11, 22
        we_base = we_cnt;
        send_byte(8'h02);
        send_byte(8'hFF);
        send_byte(8'h11);
        send_byte(8'h22);
        end_frame();
        check("burst_mem_ff", mem[8'hFF], 8'h11);
`ifdef SPI_SRAM_BURST_EN
        check("burst_mem_00", mem[8'h00], 8'h22);
        check("burst_addr", sram_addr, 8'h00);
        check("burst_we_cnt", we_cnt, we_base + 2);
`else
        check("single_mem_00", mem[8'h00], 8'h00);
        check("single_addr", sram_addr, 8'hFF);
        check("single_we_cnt", we_cnt, we_base + 1);
`endif

        // Reset mid-frame during a write data byte
        we_base = we_cnt;
        send_byte(8'h02);
        send_byte(8'h5A);
        for (int i = 0; i < 4; i++) bit_edge(1'b0, 1'b1);
        @(negedge SCK);
        rst_n = 1'b0;
        @(posedge SCK);
        #1;
        check("mrst_miso", miso, 0);
        check("mrst_addr", sram_addr, 0);
        check("mrst_din",  sram_din, 0);
        check("mrst_we",   sram_we, 0);
        check("mrst_busy", busy, 0);
        check("mrst_err",  err, 0);
        for (int i = 0; i < 6; i++) bit_edge(1'b0, 1'b1);
        check("mrst_we_cnt", we_cnt, we_base);
        check("mrst_busy_held", busy, 0);
        @(negedge SCK);
        rst_n = 1'b1;
        end_frame();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    function automatic logic CMD_BITS(input int i);
        logic [7:0] v;
        v = 8'h02;
        return v[i];
    endfunction

    function automatic logic ILL_BITS(input int i);
        logic [7:0] v;
        v = 8'h07;
        return v[i];
    endfunction

endmodule
